// File: rtl/ones_averager.sv
// Decimating averager: averages 2**LOG2_WINDOWS consecutive ones counts, valid/ack output.
// Optional threshold alarm enabled by defining ONES_AVERAGER_ALARM_EN.
module ones_averager #(
  parameter int NUMBER_OF_SAMPLES = 1650,
  parameter int LOG2_WINDOWS      = 3,
  localparam int OW               = $clog2(NUMBER_OF_SAMPLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [OW-1:0] ones_in,
  input  logic          ones_ready,
  output logic [OW-1:0] avg_out,
  output logic          avg_valid,
  input  logic          avg_ack,
  output logic          overrun,
  input  logic          clear_overrun
`ifdef ONES_AVERAGER_ALARM_EN
  ,
  input  logic [OW-1:0] thr_hi,
  input  logic [OW-1:0] thr_lo,
  output logic          alarm
`endif
);

  localparam int ACCW = OW + LOG2_WINDOWS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DISCARD = 2'd1;
  localparam logic [1:0] ST_ACCUM   = 2'd2;

  // AVG_WINDOWS-1 is all ones in a LOG2_WINDOWS-bit counter
  localparam logic [LOG2_WINDOWS-1:0] LAST_WIN = '1;

  logic [1:0]              state;
  logic [ACCW-1:0]         acc;
  logic [LOG2_WINDOWS-1:0] win_cnt;

  logic [ACCW-1:0] sum;
  logic [OW-1:0]   result;
  logic            strobe_acc;
  logic            new_result;
  logic            drop;

  always_comb begin
    sum        = acc + {{LOG2_WINDOWS{1'b0}}, ones_in};
    result     = OW'(sum >> LOG2_WINDOWS);
    strobe_acc = enable && (state == ST_ACCUM) && ones_ready;
    new_result = strobe_acc && (win_cnt == LAST_WIN);
    drop       = new_result && avg_valid && !avg_ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      win_cnt <= '0;
    end else if (!enable) begin
      state   <= ST_IDLE;
      acc     <= '0;
      win_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:    state <= ST_DISCARD;
        // first window after enable may be partial
        ST_DISCARD: if (ones_ready) state <= ST_ACCUM;
        ST_ACCUM: begin
          if (new_result) begin
            acc     <= '0;
            win_cnt <= '0;
          end else if (strobe_acc) begin
            acc     <= sum;
            win_cnt <= win_cnt + 1'b1;
          end
        end
        default:    state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else if (new_result && (!avg_valid || avg_ack)) begin
      avg_out   <= result;
      avg_valid <= 1'b1;
    end else if (avg_valid && avg_ack) begin
      avg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (clear_overrun) overrun <= 1'b0;
  end

`ifdef ONES_AVERAGER_ALARM_EN
  // tracks every computed average, including ones dropped by overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          alarm <= 1'b0;
    else if (new_result) alarm <= (result > thr_hi) || (result < thr_lo);
  end
`endif

endmodule

// File: tb/tb_ones_averager.sv
// Scoreboard bench for ones_averager (NUMBER_OF_SAMPLES=16, LOG2_WINDOWS=2).
// Define ONES_AVERAGER_ALARM_EN to also exercise the alarm outputs.
module tb_ones_averager;

  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [OW-1:0] ones_in = '0;
  logic          ones_ready = 1'b0;
  logic [OW-1:0] avg_out;
  logic          avg_valid;
  logic          avg_ack = 1'b0;
  logic          overrun;
  logic          clear_overrun = 1'b0;
`ifdef ONES_AVERAGER_ALARM_EN
  logic [OW-1:0] thr_hi = '0;
  logic [OW-1:0] thr_lo = '0;
  logic          alarm;
`endif

  ones_averager #(.NUMBER_OF_SAMPLES(16), .LOG2_WINDOWS(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .ones_in       (ones_in),
    .ones_ready    (ones_ready),
    .avg_out       (avg_out),
    .avg_valid     (avg_valid),
    .avg_ack       (avg_ack),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
`ifdef ONES_AVERAGER_ALARM_EN
    ,
    .thr_hi        (thr_hi),
    .thr_lo        (thr_lo),
    .alarm         (alarm)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned exp_q[$];

  // reference model state
  int unsigned m_st = 0;  // 0 idle, 1 discard, 2 accum
  int unsigned m_acc = 0;
  int unsigned m_cnt = 0;
  int unsigned m_avg = 0;
  bit          m_valid = 1'b0;
  bit          m_ovr = 1'b0;
  bit          m_alarm = 1'b0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_acc = 0; m_cnt = 0; m_avg = 0;
    m_valid = 1'b0; m_ovr = 1'b0; m_alarm = 1'b0;
    exp_q.delete();
  endtask

  // Drive one clock cycle of inputs; called at posedge+1, returns at next posedge+1.
  task automatic step(input bit rdy, input int unsigned val, input bit ack);
    bit          newr;
    int unsigned res;
    newr = 1'b0;
    res  = 0;
    ones_ready = rdy;
    ones_in    = OW'(val);
    avg_ack    = ack;
    if (avg_valid && ack) begin
      if (exp_q.size() == 0) check("sb_depth", 0, 1);
      else check("sb_avg", avg_out, exp_q.pop_front());
    end
    if (!enable) begin
      m_st = 0; m_acc = 0; m_cnt = 0;
    end else begin
      case (m_st)
        0: m_st = 1;
        1: if (rdy) m_st = 2;
        default: if (rdy) begin
          if (m_cnt == 3) begin
            res = (m_acc + val) / 4;
            newr = 1'b1;
            m_acc = 0; m_cnt = 0;
          end else begin
            m_acc += val; m_cnt++;
          end
        end
      endcase
    end
`ifdef ONES_AVERAGER_ALARM_EN
    if (newr) m_alarm = (res > thr_hi) || (res < thr_lo);
`endif
    if (newr && (!m_valid || ack)) begin
      exp_q.push_back(res);
      m_avg = res;
      m_valid = 1'b1;
    end else if (newr) begin
      m_ovr = 1'b1;
    end else begin
      if (m_valid && ack) m_valid = 1'b0;
    end
    if (!(newr && m_valid && !ack) && clear_overrun && !(newr && !ack && m_valid && m_avg != res))
      if (!(newr && m_ovr && !ack)) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    ones_ready    = 1'b0;
    avg_ack       = 1'b0;
    clear_overrun = 1'b0;
    check("valid", avg_valid, m_valid);
    check("avg_hold", avg_out, m_avg);
    check("overrun", overrun, m_ovr);
`ifdef ONES_AVERAGER_ALARM_EN
    check("alarm", alarm, m_alarm);
`endif
  endtask

  task automatic batch(input int unsigned v, input int unsigned n);
    for (int i = 0; i < int'(n); i++) step(1'b1, v, 1'b0);
  endtask

  initial begin
    #2;
    check("rst_avg", avg_out, 0);
    check("rst_valid", avg_valid, 0);
    check("rst_ovr", overrun, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: first strobe discarded, average of 10..13
    enable = 1'b1;
    step(1'b0, 0, 1'b0);
    step(1'b1, 9, 1'b0);
    step(1'b1, 10, 1'b0);
    step(1'b1, 11, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b1, 12, 1'b0);
    step(1'b1, 13, 1'b0);
    check("t1_avg", avg_out, 11);
    check("t1_valid", avg_valid, 1);

    // 2: unacked result, next batch dropped
    batch(16, 4);
    check("t2_avg", avg_out, 11);
    check("t2_ovr", overrun, 1);
    clear_overrun = 1'b1;
    step(1'b0, 0, 1'b0);
    check("t2_clr", overrun, 0);
    step(1'b0, 0, 1'b1);

    // 3: ack coincides with completing strobe
    batch(8, 4);
    step(1'b1, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    step(1'b1, 4, 1'b0);
    step(1'b1, 4, 1'b1);
    check("t3_valid", avg_valid, 1);
    check("t3_avg", avg_out, 2);
    check("t3_ovr", overrun, 0);
    step(1'b0, 0, 1'b1);

    // 4: enable drop clears partial batch; strobe while disabled ignored
    step(1'b1, 5, 1'b0);
    step(1'b1, 7, 1'b0);
    enable = 1'b0;
    step(1'b1, 15, 1'b0);
    step(1'b0, 0, 1'b0);
    enable = 1'b1;
    step(1'b0, 0, 1'b0);
    step(1'b1, 1, 1'b0);
    batch(8, 4);
    check("t4_avg", avg_out, 8);
    step(1'b0, 0, 1'b1);

    // 5: async reset mid-batch with pending result and overrun set
    batch(16, 4);
    batch(16, 4);
    step(1'b1, 3, 1'b0);
    step(1'b1, 3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid", avg_valid, 0);
    check("t5_ovr", overrun, 0);
    check("t5_avg", avg_out, 0);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 0, 1'b0);
    step(1'b1, 9, 1'b0);
    step(1'b1, 10, 1'b0);
    step(1'b1, 11, 1'b0);
    step(1'b1, 12, 1'b0);
    step(1'b1, 13, 1'b0);
    check("t5_avg2", avg_out, 11);
    step(1'b0, 0, 1'b1);

`ifdef ONES_AVERAGER_ALARM_EN
    // 6: threshold alarm
    thr_hi = 5'd12;
    thr_lo = 5'd4;
    batch(13, 4);
    check("t6_hi", alarm, 1);
    step(1'b0, 0, 1'b1);
    batch(8, 4);
    check("t6_mid", alarm, 0);
    step(1'b0, 0, 1'b1);
    batch(3, 4);
    check("t6_lo", alarm, 1);
    step(1'b0, 0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
